// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential PC generator plus DEPTH-entry prefetch FIFO of {pc, instr}.
// Issues at most one instruction-memory request at a time (req/gnt, then in-order rvalid),
// and only when a FIFO slot is free, so a returning word always has room.
// Decode drains the FIFO head with valid/ready. A redirect flushes the FIFO and reloads the PC;
// a response still in flight at that moment is discarded via the DRAIN state.
// Handshakes: imem transfer on o_imem_req && i_imem_gnt; decode pop on o_dq_valid && i_dq_ready;
// a valid/req output, once raised, only drops after its transfer or a redirect/reset.
// Optional feature macro: FETCH_PERF_CNT_EN adds o_perf_fetched / o_perf_dropped counters.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_dq_valid,
    input  logic            i_dq_ready,
    output logic [XLEN-1:0] o_dq_instr,
    output logic [XLEN-1:0] o_dq_pc,
    output logic [XLEN-1:0] o_dq_pc_next,
    output logic [1:0]      o_dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     o_perf_fetched,
    output logic [31:0]     o_perf_dropped
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [XLEN-1:0] r_mem_instr [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_req;
    logic            w_fire;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_nonempty;
    logic            w_has_slot;

    assign w_has_slot = (r_count < CW'(DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_fire     = w_req && i_imem_gnt;
    // Redirect wins over decode: a pop in the redirect cycle is ignored.
    assign w_pop      = o_dq_valid && i_dq_ready;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: one outstanding request; DRAIN swallows a response orphaned by a redirect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_push || w_drop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_redirect_valid) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: request only with a free slot; push or drop the response depending on redirect.
    always_comb begin
        w_req  = 1'b0;
        w_push = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so the request port is quiet while reset is held.
                w_req = i_rst_n && w_has_slot && !i_redirect_valid;
            end
            S_WAIT: begin
                w_push = i_imem_rvalid && !i_redirect_valid;
                w_drop = i_imem_rvalid && i_redirect_valid;
            end
            S_DRAIN: begin
                w_drop = i_imem_rvalid;
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    // Fetch PC: redirect reloads it, a granted request advances it (wrapping mod 2^XLEN).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            if (i_redirect_valid) begin
                r_fetch_pc <= i_redirect_pc;
            end else if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + STEP;
            end
            if (w_fire) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    // FIFO pointers and occupancy; redirect flushes, push and pop may coincide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are never visible while empty, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_req_pc;
            r_mem_instr[r_wr_ptr] <= i_imem_rdata;
        end
    end

    assign o_imem_req   = w_req;
    assign o_imem_addr  = r_fetch_pc;
    assign o_dq_valid   = w_nonempty && !i_redirect_valid;
    assign o_dq_instr   = w_nonempty ? r_mem_instr[r_rd_ptr] : '0;
    assign o_dq_pc      = w_nonempty ? r_mem_pc[r_rd_ptr] : '0;
    assign o_dq_pc_next = w_nonempty ? (r_mem_pc[r_rd_ptr] + STEP) : '0;
    assign o_dbg_state  = r_state;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [32:0] w_fetched_sum;
    logic [32:0] w_dropped_sum;

    // Dropped = discarded responses plus entries thrown away by a flush.
    assign w_fetched_sum = {1'b0, r_perf_fetched} + 33'(w_push);
    assign w_dropped_sum = {1'b0, r_perf_dropped} + 33'(w_drop)
                         + (i_redirect_valid ? 33'(r_count) : 33'd0);

    // Saturating performance counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            r_perf_fetched <= w_fetched_sum[32] ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
            r_perf_dropped <= w_dropped_sum[32] ? 32'hFFFF_FFFF : w_dropped_sum[31:0];
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_dropped = r_perf_dropped;
`else
    // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: sequential fetch, backpressure to full,
// redirect during WAIT and with a simultaneous response/pop, PC wrap, and mid-run reset.
module tb_fetch_prefetch_queue;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dq_valid;
    logic        dq_ready;
    logic [31:0] dq_instr;
    logic [31:0] dq_pc;
    logic [31:0] dq_pc_next;
    logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int n_vec;
    int n_fail;

    fetch_prefetch_queue dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_gnt       (imem_gnt),
        .i_imem_rvalid    (imem_rvalid),
        .i_imem_rdata     (imem_rdata),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_dq_valid       (dq_valid),
        .i_dq_ready       (dq_ready),
        .o_dq_instr       (dq_instr),
        .o_dq_pc          (dq_pc),
        .o_dq_pc_next     (dq_pc_next),
        .o_dbg_state      (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched   (perf_fetched),
        .o_perf_dropped   (perf_dropped)
`endif
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog bound on total runtime.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch: request seen at addr a, granted, answered the following cycle.
    task automatic fetch_one(input logic [31:0] a);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, a);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        #1;
        chk("wait_req_low", {31'd0, imem_req}, 32'd0);
        chk("wait_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("push_valid", {31'd0, dq_valid}, 32'd1);
    endtask

    initial begin
        n_vec          = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dq_ready       = 1'b0;
        #1;

        // Reset state.
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_dq_valid", {31'd0, dq_valid}, 32'd0);
        chk("rst_dq_instr", dq_instr, 32'h0);
        chk("rst_dq_pc", dq_pc, 32'h0);
        chk("rst_dq_pc_next", dq_pc_next, 32'h0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        cyc();
        cyc();

        // 1: sequential fetch with decode always ready.
        rst_n    = 1'b1;
        imem_gnt = 1'b1;
        dq_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            fetch_one(32'(k * 4));
            chk("t1_dq_pc", dq_pc, 32'(k * 4));
            chk("t1_dq_pc_next", dq_pc_next, 32'(k * 4 + 4));
            chk("t1_dq_instr", dq_instr, mem_word(32'(k * 4)));
        end

        // Drain the head without granting, leaving the FIFO empty.
        imem_gnt = 1'b0;
        #1;
        cyc();

        // 2: decode stalled, FIFO fills to exactly 4 entries.
        dq_ready = 1'b0;
        imem_gnt = 1'b1;
        #1;
        chk("t2_empty", {31'd0, dq_valid}, 32'd0);
        fetch_one(32'h0C);
        fetch_one(32'h10);
        fetch_one(32'h14);
        fetch_one(32'h18);
        chk("t2_full_req", {31'd0, imem_req}, 32'd0);
        chk("t2_full_head", dq_pc, 32'h0C);
        cyc();
        chk("t2_full_req_hold", {31'd0, imem_req}, 32'd0);
        chk("t2_head_stable", dq_pc, 32'h0C);
        chk("t2_instr_stable", dq_instr, mem_word(32'h0C));
        dq_ready = 1'b1;
        #1;
        chk("t2_pop_cycle_req", {31'd0, imem_req}, 32'd0);
        cyc();
        dq_ready = 1'b0;
        #1;
        chk("t2_next_head", dq_pc, 32'h10);
        fetch_one(32'h1C);
        chk("t2_refull_req", {31'd0, imem_req}, 32'd0);
        chk("t2_refull_head", dq_pc, 32'h10);

        // 3: redirect while WAIT, stale response two cycles later.
        dq_ready = 1'b1;
        #1;
        cyc();
        dq_ready = 1'b0;
        #1;
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h20);
        chk("t3_head", dq_pc, 32'h14);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_redir_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
        chk("t3_redir_dq_valid", {31'd0, dq_valid}, 32'd0);
        chk("t3_redir_req", {31'd0, imem_req}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        chk("t3_drain_state", {30'd0, dbg_state}, {30'd0, S_DRAIN});
        chk("t3_drain_addr", imem_addr, 32'h100);
        chk("t3_drain_req", {31'd0, imem_req}, 32'd0);
        chk("t3_flushed", {31'd0, dq_valid}, 32'd0);
        cyc();
        chk("t3_drain_hold", {30'd0, dbg_state}, {30'd0, S_DRAIN});
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("t3_drain_req2", {31'd0, imem_req}, 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("t3_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        chk("t3_stale_dropped", {31'd0, dq_valid}, 32'd0);
        fetch_one(32'h100);
        chk("t3_dq_pc", dq_pc, 32'h100);
        chk("t3_dq_pc_next", dq_pc_next, 32'h104);
        chk("t3_dq_instr", dq_instr, mem_word(32'h100));

        // 4: redirect coinciding with a response and a pop attempt.
        chk("t4_addr", imem_addr, 32'h104);
        cyc();
        imem_rvalid    = 1'b1;
        imem_rdata     = mem_word(32'h104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        dq_ready       = 1'b1;
        #1;
        chk("t4_forced_invalid", {31'd0, dq_valid}, 32'd0);
        cyc();
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dq_ready       = 1'b0;
        #1;
        chk("t4_empty", {31'd0, dq_valid}, 32'd0);
        chk("t4_dq_pc_zero", dq_pc, 32'h0);
        chk("t4_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr_new", imem_addr, 32'h200);

        // 5: PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("t5_redir_req", {31'd0, imem_req}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dq_ready       = 1'b1;
        #1;
        fetch_one(32'hFFFF_FFFC);
        chk("t5_dq_pc", dq_pc, 32'hFFFF_FFFC);
        chk("t5_dq_pc_next", dq_pc_next, 32'h0);
        chk("t5_wrap_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_perf_fetched", perf_fetched, 32'd10);
        chk("t5_perf_dropped", perf_dropped, 32'd6);
`endif

        // 6: reset asserted with 3 entries and a request pending.
        dq_ready = 1'b0;
        #1;
        fetch_one(32'h0);
        fetch_one(32'h4);
        chk("t6_pending_req", {31'd0, imem_req}, 32'd1);
        chk("t6_pending_addr", imem_addr, 32'h8);
        chk("t6_head", dq_pc, 32'hFFFF_FFFC);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        rst_n       = 1'b0;
        #1;
        chk("t6_rst_dq_valid", {31'd0, dq_valid}, 32'd0);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_dq_pc", dq_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_rst_perf_fetched", perf_fetched, 32'd0);
        chk("t6_rst_perf_dropped", perf_dropped, 32'd0);
`endif
        cyc();
        chk("t6_rst_hold_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t6_release_req", {31'd0, imem_req}, 32'd1);
        chk("t6_release_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("t6_late_rvalid_ignored", {31'd0, dq_valid}, 32'd0);
        chk("t6_late_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
